mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one external memory port between the fetch stage (I-side, read-only) and the
//  data-memory stage (D-side, load/store) of the 5-stage RISC-V core.
//  Sits between the core's mem_i_* / mem_d_* interfaces and a single variable-latency memory.
//  Allows one outstanding transaction. D-side has priority, with an I-side starvation guard.
// PARAMETERS
//  ADDR_W        32  address width, both requesters and the memory
//  DATA_W        32  data width
//  MASK_W        4   write byte-mask width (DATA_W/8)
//  MAX_D_STREAK  4   max consecutive contested D grants before I is forced (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-low (0 = in reset)
//  i_req      in   1       fetch request; held, with i_addr stable, until i_ack
//  i_addr     in   ADDR_W  fetch address
//  i_rdata    out  DATA_W  fetch data, valid when i_ack=1
//  i_ack      out  1       one-cycle completion pulse to fetch
//  d_req      in   1       data request; held, with d_* fields stable, until d_ack
//  d_we       in   1       1 = store, 0 = load
//  d_wmask    in   MASK_W  store byte enables
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid when d_ack=1 (undefined for stores)
//  d_ack      out  1       one-cycle completion pulse to data stage
//  mem_req    out  1       request to memory; held, with fields stable, until mem_gnt
//  mem_we     out  1       write enable (0 for every I transaction)
//  mem_wmask  out  MASK_W  byte mask (0 for every I transaction)
//  mem_addr   out  ADDR_W  address
//  mem_wdata  out  DATA_W  write data
//  mem_gnt    in   1       memory accepted the request this cycle (mem_req & mem_gnt)
//  mem_rvalid in   1       response; read data or write-done, exactly one per accepted request
//  mem_rdata  in   DATA_W  read data, valid with mem_rvalid
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, d_streak=0; mem_req, mem_we, i_ack, d_ack = 0;
//    mem_wmask, mem_addr, mem_wdata, i_rdata, d_rdata = 0.
//  - FSM states:
//    IDLE -> REQ   on any request; winner's fields latched into mem_* registers.
//    REQ  -> WAIT  on mem_gnt. mem_req=1 throughout REQ.
//    WAIT -> RESP  on mem_rvalid; mem_rdata registered into the winner's rdata.
//    RESP -> IDLE  unconditionally; the winner's ack=1 for this single cycle.
//  - Every output is registered; there is no combinational path from inputs to outputs.
//  - Min latency: req sampled in cycle t; mem_req t+1; gnt t+1; rvalid t+2; ack t+3.
//  - Requests are sampled only in IDLE. A req still high in the RESP (ack) cycle counts as
//    a new request, sampled in the following IDLE cycle.
//  - Arbitration in IDLE:
//    * Only one req: that side wins.
//    * Both req: D wins if d_streak < MAX_D_STREAK, else I wins.
//    * d_streak increments (saturating) on a D grant taken while i_req=1.
//    * d_streak clears on any I grant.
//    * d_streak holds on an uncontested D grant.
//  - Winner's mem fields stay constant from entry into REQ until RESP; the requester's later
//    input changes are ignored.
//  - Ack routing:
//    * Non-winner's ack stays 0.
//    * The rdata of the non-winning side holds its previous value.
//    * I winner: mem_we=0, mem_wmask=0 regardless of d_* inputs.
//  - Boundaries:
//    * mem_rvalid in IDLE/REQ/RESP: ignored (no ack, no rdata update).
//    * mem_gnt outside REQ: ignored.
//    * mem_gnt and mem_rvalid in the same REQ cycle: go to WAIT only; that rvalid is ignored
//      (the memory must not respond in its grant cycle).
//    * d_we=1 with d_wmask=0: forwarded unchanged.
//    * Reset mid-transaction: abandons it immediately. The memory must be reset with the core.
// STRUCTURE
//  - defines.sv gets the typedef arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP}.
//  - defines.sv gets the typedef arb_owner_t {OWN_I, OWN_D}.
//  - Streak counter width is $clog2(MAX_D_STREAK+1), local to this module.
//  - One sub-module: mem_arb_pick. It is combinational and takes i_req, d_req, d_streak;
//    it returns grant_valid and grant_owner.
//  - The FSM, latches and counter stay in mem_port_arbiter.
// TESTING
//  1. Single load: d_req, d_addr=0x100, d_we=0; gnt on first REQ cycle; rvalid next cycle
//     with rdata=0xDEADBEEF -> d_ack 1 cycle at t+3, d_rdata=0xDEADBEEF, i_ack=0 throughout.
//  2. Store: d_we=1, d_wmask=4'b0011, d_wdata=0x12345678 -> mem_we=1, mem_wmask=0011,
//     fields stable while gnt held low 5 cycles; d_ack one cycle after rvalid.
//  3. Contention, MAX_D_STREAK=4, i_req and d_req held high -> grant order D,D,D,D,I,
//     then D again; every I transaction has mem_we=0 and mem_wmask=0.
//  4. Back-to-back: i_req kept high across ack, new i_addr=0x4 after ack ->
//     next mem_req asserts with mem_addr=0x4; no duplicate ack.
//  5. Stray mem_rvalid in IDLE and in REQ -> no ack, rdata unchanged, state unchanged.
//  6. reset pulled low in WAIT -> all outputs 0 immediately. After release, a late
//     mem_rvalid is ignored and the next d_req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner,
// and default widths used by the top level and the pick sub-module.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int unsigned ARB_ADDR_W       = 32;
    localparam int unsigned ARB_DATA_W       = 32;
    localparam int unsigned ARB_MASK_W       = ARB_DATA_W / 8;
    localparam int unsigned ARB_MAX_D_STREAK = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between the fetch (I) and data (D) sides.
// D normally wins a contested cycle; once D has taken MAX_D_STREAK contested
// grants in a row, I is forced through so fetch cannot starve.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] d_streak,
    output logic             grant_valid,
    output arb_owner_t       grant_owner
);

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    // Pick the winner: D unless I is also waiting and D has used up its streak.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (d_req && (!i_req || (d_streak < STREAK_MAX))) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between the fetch and data stages.
// One transaction is outstanding at a time; all outputs are registered.
//
// Handshakes: a requester raises *_req with its fields stable and holds them
// until its one-cycle *_ack pulse. Towards memory, mem_req is held with stable
// fields until the cycle where mem_req & mem_gnt; exactly one mem_rvalid
// follows in a later cycle. Requests are only looked at while idle, so a req
// still high during the ack cycle is treated as a fresh request.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int MASK_W       = ARB_MASK_W,
    parameter int MAX_D_STREAK = ARB_MAX_D_STREAK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [MASK_W-1:0] d_wmask,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [CNT_W-1:0]  streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;

    logic              grant_valid;
    arb_owner_t        grant_owner;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .d_streak    (streak_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Next-state logic: arbitrate in IDLE, hold the memory request until
    // granted, capture the response for the owner, then pulse its ack.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wmask_d = mem_wmask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_d   = ARB_REQ;
                    owner_d   = grant_owner;
                    mem_req_d = 1'b1;
                    if (grant_owner == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_wmask_d = d_wmask;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // Only contested D grants count towards the streak.
                        if (i_req && (streak_q != STREAK_MAX)) begin
                            streak_d = streak_q + CNT_W'(1);
                        end
                    end else begin
                        // Fetch is read-only: never let store fields leak out.
                        mem_we_d    = 1'b0;
                        mem_wmask_d = '0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end
                end
            end
            ARB_REQ: begin
                // A response in the grant cycle itself is not accepted.
                if (mem_gnt) begin
                    state_d   = ARB_WAIT;
                    mem_req_d = 1'b0;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ARB_RESP;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_I;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wmask_q <= mem_wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: job-queue requesters, a randomised memory model,
// and a monitor that predicts each grant and its response from the arbitration
// rules, pushing expectations into exp_q and popping them on every ack.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MW   = 4;
    localparam int MAXS = 4;
    localparam int EW   = 34;  // {owner_is_d, is_load, rdata}

    typedef struct {
        logic          we;
        logic [MW-1:0] mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } job_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          i_req, i_ack, d_req, d_we, d_ack;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic [MW-1:0] d_wmask, mem_wmask;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .MAX_D_STREAK(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // ---------------- bookkeeping ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
    endtask

    // Memory contents seen by both the model and the expectation.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- snapshot of what the DUT samples ----------------
    logic          snap_i_req, snap_d_req, snap_d_we, snap_rv_real;
    logic [AW-1:0] snap_i_addr, snap_d_addr;
    logic [DW-1:0] snap_d_wdata;
    logic [MW-1:0] snap_d_wmask;
    logic          rv_real;

    always @(posedge clk) begin
        snap_i_req   <= i_req;
        snap_i_addr  <= i_addr;
        snap_d_req   <= d_req;
        snap_d_we    <= d_we;
        snap_d_wmask <= d_wmask;
        snap_d_addr  <= d_addr;
        snap_d_wdata <= d_wdata;
        snap_rv_real <= rv_real;
    end

    // ---------------- requester drivers ----------------
    job_t i_jobs[$];
    job_t d_jobs[$];
    bit   i_busy = 0;
    bit   d_busy = 0;
    int unsigned d_issue_cyc = 0;
    int unsigned d_done_cyc = 0;

    task automatic push_i(input logic [AW-1:0] addr, input int gap);
        job_t j;
        j.we = 1'b0; j.mask = '0; j.addr = addr; j.wdata = '0; j.gap = gap;
        i_jobs.push_back(j);
    endtask

    task automatic push_d(input logic we, input logic [MW-1:0] mask, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int gap);
        job_t j;
        j.we = we; j.mask = mask; j.addr = addr; j.wdata = wdata; j.gap = gap;
        d_jobs.push_back(j);
    endtask

    initial begin
        job_t j;
        i_req = 1'b0; i_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                i_busy = 0;
                i_req  = 1'b0;
            end else begin
                if (i_busy && i_ack === 1'b1) i_busy = 0;
                if (!i_busy && i_jobs.size() > 0) begin
                    j = i_jobs[0];
                    if (j.gap > 0) begin
                        j.gap = j.gap - 1;
                        i_jobs[0] = j;
                    end else begin
                        j = i_jobs.pop_front();
                        i_addr = j.addr;
                        i_busy = 1;
                    end
                end
                i_req = i_busy;
            end
        end
    end

    initial begin
        job_t j;
        d_req = 1'b0; d_we = 1'b0; d_wmask = '0; d_addr = '0; d_wdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                d_busy = 0;
                d_req  = 1'b0;
            end else begin
                if (d_busy && d_ack === 1'b1) begin
                    d_busy = 0;
                    d_done_cyc = cyc;
                end
                if (!d_busy && d_jobs.size() > 0) begin
                    j = d_jobs[0];
                    if (j.gap > 0) begin
                        j.gap = j.gap - 1;
                        d_jobs[0] = j;
                    end else begin
                        j = d_jobs.pop_front();
                        d_we = j.we; d_wmask = j.mask; d_addr = j.addr; d_wdata = j.wdata;
                        d_busy = 1;
                        d_issue_cyc = cyc;
                    end
                end
                d_req = d_busy;
            end
        end
    end

    // ---------------- memory model ----------------
    int gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0, stray_pct = 0;
    int stray_req_cnt = 0;
    int stray_done_cnt = 0;
    int mstate = 0;  // 0 idle, 1 awaiting grant, 2 awaiting response
    int mcnt = 0;
    logic [DW-1:0] r_data;

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rv_real = 1'b0; r_data = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            rv_real    = 1'b0;
            if (!reset) begin
                mstate  = 0;
                mem_gnt = 1'b0;
            end else begin
                if (mstate == 0 && mem_req === 1'b1) begin
                    mcnt   = $urandom_range(gnt_max, gnt_min);
                    mstate = 1;
                end
                if (mstate == 1) begin
                    if (mem_gnt) begin
                        mem_gnt = 1'b0;
                        mcnt    = $urandom_range(rv_max, rv_min);
                        mstate  = 2;
                    end else if (mcnt == 0) begin
                        mem_gnt = 1'b1;
                        r_data  = mem_we ? $urandom : mem_fn(mem_addr);
                    end else begin
                        mcnt--;
                    end
                end
                if (mstate == 2) begin
                    if (mcnt == 0) begin
                        mem_rvalid = 1'b1;
                        rv_real    = 1'b1;
                        mem_rdata  = r_data;
                        mstate     = 0;
                    end else begin
                        mcnt--;
                    end
                end
                // Stray responses only outside the WAIT phase.
                if (!rv_real && mstate != 2 &&
                    (stray_req_cnt != stray_done_cnt || $urandom_range(99, 0) < stray_pct)) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
                stray_done_cnt = stray_req_cnt;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0]  exp_q[$];
    bit             grant_hist[$];
    int             m_streak = 0;
    bit             req_prev = 0;
    logic [127:0]   exp_fld = '0;
    bit             fld_has_wdata = 0;
    logic [DW-1:0]  m_i_rdata = '0;
    logic [DW-1:0]  m_d_rdata = '0;
    bit             d_known = 1;
    int             ack_i_n = 0;
    int             ack_d_n = 0;
    logic [AW-1:0]  last_i_addr = '0;

    initial begin
        bit            win_d;
        logic [EW-1:0] e;
        logic [127:0]  got_fld;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_streak = 0; req_prev = 0; m_i_rdata = '0; m_d_rdata = '0; d_known = 1;
                exp_q.delete();
            end else begin
                got_fld = fld_has_wdata ? {mem_we, mem_wmask, mem_addr, mem_wdata}
                                        : {mem_we, mem_wmask, mem_addr};
                if (mem_req === 1'b1 && !req_prev) begin
                    if (!snap_i_req && !snap_d_req) begin
                        timeout_fail("spurious_mem_req");
                    end else begin
                        win_d = snap_d_req && (!snap_i_req || m_streak < MAXS);
                        if (win_d) begin
                            if (snap_i_req && m_streak < MAXS) m_streak++;
                            fld_has_wdata = 1;
                            exp_fld = {snap_d_we, snap_d_wmask, snap_d_addr, snap_d_wdata};
                            got_fld = {mem_we, mem_wmask, mem_addr, mem_wdata};
                            exp_q.push_back({1'b1, !snap_d_we, mem_fn(snap_d_addr)});
                        end else begin
                            m_streak = 0;
                            fld_has_wdata = 0;
                            exp_fld = {1'b0, {MW{1'b0}}, snap_i_addr};
                            got_fld = {mem_we, mem_wmask, mem_addr};
                            exp_q.push_back({1'b0, 1'b1, mem_fn(snap_i_addr)});
                            last_i_addr = mem_addr;
                        end
                        grant_hist.push_back(win_d);
                        check("issue_fields", got_fld, exp_fld);
                    end
                end else if (mem_req === 1'b1) begin
                    check("req_stable", got_fld, exp_fld);
                end
                req_prev = (mem_req === 1'b1);

                check("ack_timing", i_ack | d_ack, snap_rv_real);
                if (i_ack || d_ack) begin
                    check("ack_both", i_ack & d_ack, 1'b0);
                    ack_i_n += int'(i_ack);
                    ack_d_n += int'(d_ack);
                    if (exp_q.size() == 0) begin
                        timeout_fail("ack_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_owner", d_ack, e[33]);
                        if (e[33]) begin
                            d_known = e[32];
                            m_d_rdata = e[31:0];
                        end else begin
                            m_i_rdata = e[31:0];
                        end
                    end
                end
                check("i_rdata", i_rdata, m_i_rdata);
                if (d_known) check("d_rdata", d_rdata, m_d_rdata);
            end
        end
    end

    // ---------------- helpers for the main sequence ----------------
    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(i_jobs.size() == 0 && d_jobs.size() == 0 && !i_busy && !d_busy &&
                 exp_q.size() == 0 && mem_req === 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) timeout_fail(name);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_mem_req"},   mem_req,   1'b0);
        check({name, "_mem_we"},    mem_we,    1'b0);
        check({name, "_mem_wmask"}, mem_wmask, '0);
        check({name, "_mem_addr"},  mem_addr,  '0);
        check({name, "_mem_wdata"}, mem_wdata, '0);
        check({name, "_i_rdata"},   i_rdata,   '0);
        check({name, "_d_rdata"},   d_rdata,   '0);
        check({name, "_i_ack"},     i_ack,     1'b0);
        check({name, "_d_ack"},     d_ack,     1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base, base_i, base_d, hist_base, n;
        logic [5:0] order;

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // 1: single load, minimum latency
        gnt_min = 0; gnt_max = 0; rv_min = 0; rv_max = 0; stray_pct = 0;
        push_d(1'b0, 4'h0, 32'h0000_0100, 32'h0, 0);
        wait_idle("t1_wait", 50);
        check("t1_latency", d_done_cyc - d_issue_cyc, 3);
        check("t1_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("t1_no_i_ack", ack_i_n, 0);

        // 2: store with grant withheld for 5 cycles
        gnt_min = 5; gnt_max = 5; rv_min = 1; rv_max = 1;
        push_d(1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678, 0);
        wait_idle("t2_wait", 60);
        check("t2_d_acks", ack_d_n, 2);

        // 3: contention, both sides held high
        gnt_min = 0; gnt_max = 1; rv_min = 0; rv_max = 1;
        hist_base = grant_hist.size();
        for (int k = 0; k < 5; k++) push_d(1'b0, 4'h0, 32'h8000_0000 + 32'(k * 4), 32'h0, 0);
        for (int k = 0; k < 2; k++) push_i(32'h0000_0040 + 32'(k * 4), 0);
        wait_idle("t3_wait", 200);
        order = '0;
        if (grant_hist.size() < hist_base + 6) begin
            timeout_fail("t3_grant_count");
        end else begin
            for (int k = 0; k < 6; k++) order = {order[4:0], grant_hist[hist_base + k]};
            check("t3_order", order, 6'b111101);
        end

        // 4: back-to-back fetches, address changes in the ack cycle
        base_i = ack_i_n;
        push_i(32'h0000_0000, 0);
        push_i(32'h0000_0004, 0);
        wait_idle("t4_wait", 60);
        check("t4_i_acks", ack_i_n - base_i, 2);
        check("t4_last_addr", last_i_addr, 32'h0000_0004);

        // 5: stray responses in IDLE and REQ
        stray_pct = 100; gnt_min = 3; gnt_max = 3; rv_min = 0; rv_max = 0;
        repeat (4) @(negedge clk);
        base_d = ack_d_n;
        push_d(1'b0, 4'h0, 32'h8000_1230, 32'h0, 0);
        wait_idle("t5_wait", 60);
        stray_pct = 0;
        check("t5_d_acks", ack_d_n - base_d, 1);

        // random mixed traffic
        gnt_min = 0; gnt_max = 3; rv_min = 0; rv_max = 3; stray_pct = 15;
        base = ack_i_n + ack_d_n;
        for (int k = 0; k < 60; k++) begin
            push_i({4'h0, 26'($urandom), 2'b00}, $urandom_range(4, 0));
            push_d($urandom_range(1, 0), 4'($urandom_range(15, 0)),
                   {4'h8, 26'($urandom), 2'b00}, $urandom, $urandom_range(4, 0));
        end
        wait_idle("rand_wait", 5000);
        stray_pct = 0;
        check("rand_acks", ack_i_n + ack_d_n - base, 120);

        // 6: reset during WAIT, then a late response and a clean load
        gnt_min = 0; gnt_max = 0; rv_min = 6; rv_max = 6;
        push_d(1'b0, 4'h0, 32'h0000_0300, 32'h0, 0);
        n = 0;
        while (mstate != 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("t6_reach_wait");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rv_min = 0; rv_max = 0;
        @(negedge clk);
        stray_req_cnt++;
        repeat (3) @(negedge clk);
        base_d = ack_d_n;
        push_d(1'b0, 4'h0, 32'h0000_0104, 32'h0, 0);
        wait_idle("t6_wait", 60);
        check("t6_d_acks", ack_d_n - base_d, 1);
        check("t6_d_rdata", d_rdata, mem_fn(32'h0000_0104));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global safety net so the run always ends.
    initial begin
        #2_000_000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
